// File: rtl/vector_elem_sequencer_if.sv
// rtl/vector_elem_sequencer_if.sv - operation handshake and element-group issue bundle
interface vector_elem_sequencer_if #(
  parameter int NUM_LANES = 4,
  parameter int VLEN      = 128,
  parameter int VL_W      = $clog2(VLEN) + 1
);
  logic                 start;
  logic                 start_ready;
  logic [VL_W-1:0]      vl;
  logic [VL_W-1:0]      vstart;
  logic                 serial;
  logic                 stall;
  logic                 flush;
  logic                 issue_valid;
  logic [VL_W-1:0]      base_idx;
  logic [NUM_LANES-1:0] lane_active;
  logic                 first;
  logic                 last;
  logic                 busy;
  logic                 done;

  modport master (
    output start, vl, vstart, serial, stall, flush,
    input  start_ready, issue_valid, base_idx, lane_active, first, last, busy, done
  );

  modport slave (
    input  start, vl, vstart, serial, stall, flush,
    output start_ready, issue_valid, base_idx, lane_active, first, last, busy, done
  );
endinterface

// File: rtl/vector_elem_sequencer.sv
// rtl/vector_elem_sequencer.sv - walks a vector op's element index space in lane-wide groups
module vector_elem_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int VLEN      = 128,
  parameter int VL_W      = $clog2(VLEN) + 1
) (
  input logic                    CLK,
  input logic                    RST,
  vector_elem_sequencer_if.slave seq
);
  localparam int XW = VL_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [VL_W-1:0]      vl_q, vl_d;
  logic                 ser_q, ser_d;
  logic [VL_W-1:0]      base_q, base_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic [NUM_LANES-1:0] lanes_q, lanes_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  function automatic logic [XW-1:0] step_of(input logic ser);
    return ser ? XW'(1) : XW'(NUM_LANES);
  endfunction

  // Sums are taken one bit wider than VL_W so a group ending at vl = VLEN cannot wrap.
  function automatic logic [NUM_LANES-1:0] lanes_for(input logic [VL_W-1:0] b,
                                                     input logic [VL_W-1:0] n,
                                                     input logic            ser);
    logic [NUM_LANES-1:0] lanes;
    lanes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lanes[i] = (({1'b0, b} + XW'(i)) < {1'b0, n}) && (!ser || (i == 0));
    end
    return lanes;
  endfunction

  always_comb begin
    state_d = state_q;
    vl_d    = vl_q;
    ser_d   = ser_q;
    base_d  = base_q;
    first_d = first_q;
    unique case (state_q)
      S_IDLE: begin
        if (seq.start) begin
          vl_d    = seq.vl;
          ser_d   = seq.serial;
          first_d = 1'b1;
          if (seq.vstart < seq.vl) begin
            state_d = S_RUN;
            base_d  = seq.vstart;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_RUN: begin
        if (seq.flush) begin
          state_d = S_IDLE;
        end else if (!seq.stall) begin
          if (last_q) begin
            state_d = S_FIN;
          end else begin
            base_d  = base_q + VL_W'(step_of(ser_q));
            first_d = 1'b0;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Group outputs are derived from the next-state values so every output is a flop.
  always_comb begin
    valid_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    lanes_d = valid_d ? lanes_for(base_d, vl_d, ser_d) : '0;
    last_d  = valid_d && (({1'b0, base_d} + step_of(ser_d)) >= {1'b0, vl_d});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      vl_q    <= '0;
      ser_q   <= 1'b0;
      base_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      lanes_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vl_q    <= vl_d;
      ser_q   <= ser_d;
      base_q  <= base_d;
      first_q <= valid_d && first_d;
      last_q  <= last_d;
      lanes_q <= lanes_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign seq.start_ready = (state_q == S_IDLE);
  assign seq.issue_valid = valid_q;
  assign seq.base_idx    = base_q;
  assign seq.lane_active = lanes_q;
  assign seq.first       = first_q;
  assign seq.last        = last_q;
  assign seq.busy        = busy_q;
  assign seq.done        = done_q;
endmodule

// File: tb/tb_vector_elem_sequencer.sv
// tb/tb_vector_elem_sequencer.sv - directed self-checking bench for vector_elem_sequencer
module tb_vector_elem_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vector_elem_sequencer_if #(.NUM_LANES(4), .VLEN(128)) bus ();

  vector_elem_sequencer #(.NUM_LANES(4), .VLEN(128)) dut (
    .CLK (clk),
    .RST (rst),
    .seq (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".start_ready"}, 32'(bus.start_ready), 32'd1);
    check({tag, ".issue_valid"}, 32'(bus.issue_valid), 32'd0);
    check({tag, ".busy"},        32'(bus.busy),        32'd0);
    check({tag, ".done"},        32'(bus.done),        32'd0);
  endtask

  task automatic do_start(input int vl, input int vstart, input bit ser);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.vl     = 8'(vl);
    bus.vstart = 8'(vstart);
    bus.serial = ser;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.vl     = 8'hff;
    bus.vstart = 8'h55;
    bus.serial = ~ser;
  endtask

  task automatic exp_group(input string tag, input int base, input logic [3:0] lanes,
                           input bit f, input bit l);
    check({tag, ".valid"}, 32'(bus.issue_valid), 32'd1);
    check({tag, ".base"},  32'(bus.base_idx),    32'(base));
    check({tag, ".lanes"}, 32'(bus.lane_active), 32'(lanes));
    check({tag, ".first"}, 32'(bus.first),       32'(f));
    check({tag, ".last"},  32'(bus.last),        32'(l));
    check({tag, ".busy"},  32'(bus.busy),        32'd1);
    @(negedge clk);
  endtask

  task automatic exp_done(input string tag);
    check({tag, ".done"},  32'(bus.done),        32'd1);
    check({tag, ".valid"}, 32'(bus.issue_valid), 32'd0);
    check({tag, ".ready"}, 32'(bus.start_ready), 32'd0);
    @(negedge clk);
    check_idle_outputs({tag, ".after"});
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.vl     = '0;
    bus.vstart = '0;
    bus.serial = 1'b0;
    bus.stall  = 1'b0;
    bus.flush  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("rst");
    check("rst.base",  32'(bus.base_idx),    32'd0);
    check("rst.lanes", 32'(bus.lane_active), 32'd0);
    check("rst.first", 32'(bus.first),       32'd0);
    check("rst.last",  32'(bus.last),        32'd0);

    // 1: basic parallel
    do_start(10, 0, 1'b0);
    exp_group("p.g1", 0, 4'b1111, 1'b1, 1'b0);
    exp_group("p.g2", 4, 4'b1111, 1'b0, 1'b0);
    exp_group("p.g3", 8, 4'b0011, 1'b0, 1'b1);
    exp_done("p");

    // 2: single partial group; flush in IDLE must not block the start
    @(negedge clk);
    bus.flush  = 1'b1;
    bus.start  = 1'b1;
    bus.vl     = 8'd5;
    bus.vstart = 8'd3;
    bus.serial = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    exp_group("one", 3, 4'b0011, 1'b1, 1'b1);
    exp_done("one");

    // 3: empty operations
    do_start(7, 7, 1'b0);
    exp_done("emp7");
    do_start(0, 0, 1'b0);
    exp_done("emp0");

    // 4: serial
    do_start(3, 0, 1'b1);
    exp_group("s.b0", 0, 4'b0001, 1'b1, 1'b0);
    exp_group("s.b1", 1, 4'b0001, 1'b0, 1'b0);
    exp_group("s.b2", 2, 4'b0001, 1'b0, 1'b1);
    exp_done("s");

    // 5: stall two cycles on group 1
    do_start(8, 0, 1'b0);
    bus.stall = 1'b1;
    exp_group("st.g1a", 0, 4'b1111, 1'b1, 1'b0);
    exp_group("st.g1b", 0, 4'b1111, 1'b1, 1'b0);
    bus.stall = 1'b0;
    exp_group("st.g1c", 0, 4'b1111, 1'b1, 1'b0);
    exp_group("st.g2",  4, 4'b1111, 1'b0, 1'b1);
    exp_done("st");

    // 6a: flush on group 2, stall held too (flush wins)
    do_start(16, 0, 1'b0);
    exp_group("fl.g1", 0, 4'b1111, 1'b1, 1'b0);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    check("fl.g2.base", 32'(bus.base_idx), 32'd4);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    check_idle_outputs("fl.idle");
    @(negedge clk);
    check_idle_outputs("fl.nodone");

    // 6b: reset mid-run
    do_start(16, 0, 1'b0);
    exp_group("rr.g1", 0, 4'b1111, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("rr");
    check("rr.base",  32'(bus.base_idx),    32'd0);
    check("rr.lanes", 32'(bus.lane_active), 32'd0);
    check("rr.first", 32'(bus.first),       32'd0);
    check("rr.last",  32'(bus.last),        32'd0);
    @(negedge clk);
    check("rr.nodone", 32'(bus.done), 32'd0);

    // 6c: full-length vector, no index wrap at vl = VLEN
    do_start(128, 0, 1'b0);
    for (int g = 0; g < 32; g++) begin
      exp_group($sformatf("full.g%0d", g), 4 * g, 4'b1111, g == 0, g == 31);
    end
    exp_done("full");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
